// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register of the 5-stage MIPS-style CPU
//
// Purpose:
//   Captures decode-stage operands, register specifiers, immediate, funct and
//   control bits on every rising clock edge and presents them to the execute
//   stage one cycle later. stallID freezes the stage while decode is stalled.
//   Clearing every field (reset) produces a NOP bubble: no memory access and
//   no register write.
//
// Optional feature (macro ID_EX_FLUSH_EN):
//   Adds i_flush. A flushed edge zeroes all control outputs while data and
//   specifier outputs still load. Flush overrides stall; reset overrides flush.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_flush          bubble request (only with ID_EX_FLUSH_EN)
//   stallID          1 = hold all outputs, 0 = load inputs
//   ID_Rs/ID_Rt      register-file read data (NBITS)
//   ID_rd/ID_rt      destination specifiers (RBITS)
//   ID_funct         R-type funct field (FBITS)
//   ID_immediate     extended immediate (NBITS)
//   ID_memtoreg, ID_memread, ID_memwrite, ID_alusource, ID_link, ID_regwrite
//                    1-bit control
//   ID_aluop (3), ID_regdst (2), ID_sizecontrol (5)  multi-bit control
//   EX_*             registered copy of each ID_* input

module id_ex_pipe_reg #(
  parameter int NBITS = 32,
  parameter int RBITS = 5,
  parameter int FBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef ID_EX_FLUSH_EN
  input  logic             i_flush,
`endif
  input  logic             stallID,
  input  logic [NBITS-1:0] ID_Rs,
  input  logic [NBITS-1:0] ID_Rt,
  input  logic [RBITS-1:0] ID_rd,
  input  logic [RBITS-1:0] ID_rt,
  input  logic [FBITS-1:0] ID_funct,
  input  logic [NBITS-1:0] ID_immediate,
  input  logic             ID_memtoreg,
  input  logic             ID_memread,
  input  logic             ID_memwrite,
  input  logic             ID_alusource,
  input  logic             ID_link,
  input  logic             ID_regwrite,
  input  logic [2:0]       ID_aluop,
  input  logic [1:0]       ID_regdst,
  input  logic [4:0]       ID_sizecontrol,
  output logic [NBITS-1:0] EX_Rs,
  output logic [NBITS-1:0] EX_Rt,
  output logic [RBITS-1:0] EX_rd,
  output logic [RBITS-1:0] EX_rt,
  output logic [FBITS-1:0] EX_funct,
  output logic [NBITS-1:0] EX_immediate,
  output logic             EX_memtoreg,
  output logic             EX_memread,
  output logic             EX_memwrite,
  output logic             EX_alusource,
  output logic             EX_link,
  output logic             EX_regwrite,
  output logic [2:0]       EX_aluop,
  output logic [1:0]       EX_regdst,
  output logic [4:0]       EX_sizecontrol
);

  // Data / specifier fields
  logic [NBITS-1:0] r_rs;
  logic [NBITS-1:0] r_rt_data;
  logic [RBITS-1:0] r_rd;
  logic [RBITS-1:0] r_rt;
  logic [FBITS-1:0] r_funct;
  logic [NBITS-1:0] r_imm;

  // Control fields
  logic             r_memtoreg;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_alusource;
  logic             r_link;
  logic             r_regwrite;
  logic [2:0]       r_aluop;
  logic [1:0]       r_regdst;
  logic [4:0]       r_sizecontrol;

  // Data fields load whenever the stage advances; a flush forces an advance
  // even during a stall so the bubble carries the current operands.
  logic w_load_data;
  logic w_load_ctrl;
  logic w_clear_ctrl;

`ifdef ID_EX_FLUSH_EN
  assign w_load_data  = i_flush | ~stallID;
  assign w_clear_ctrl = i_flush;
  assign w_load_ctrl  = ~i_flush & ~stallID;
`else
  assign w_load_data  = ~stallID;
  assign w_clear_ctrl = 1'b0;
  assign w_load_ctrl  = ~stallID;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rs      <= '0;
      r_rt_data <= '0;
      r_rd      <= '0;
      r_rt      <= '0;
      r_funct   <= '0;
      r_imm     <= '0;
    end else if (w_load_data) begin
      r_rs      <= ID_Rs;
      r_rt_data <= ID_Rt;
      r_rd      <= ID_rd;
      r_rt      <= ID_rt;
      r_funct   <= ID_funct;
      r_imm     <= ID_immediate;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_memtoreg    <= 1'b0;
      r_memread     <= 1'b0;
      r_memwrite    <= 1'b0;
      r_alusource   <= 1'b0;
      r_link        <= 1'b0;
      r_regwrite    <= 1'b0;
      r_aluop       <= '0;
      r_regdst      <= '0;
      r_sizecontrol <= '0;
    end else if (w_clear_ctrl) begin
      r_memtoreg    <= 1'b0;
      r_memread     <= 1'b0;
      r_memwrite    <= 1'b0;
      r_alusource   <= 1'b0;
      r_link        <= 1'b0;
      r_regwrite    <= 1'b0;
      r_aluop       <= '0;
      r_regdst      <= '0;
      r_sizecontrol <= '0;
    end else if (w_load_ctrl) begin
      r_memtoreg    <= ID_memtoreg;
      r_memread     <= ID_memread;
      r_memwrite    <= ID_memwrite;
      r_alusource   <= ID_alusource;
      r_link        <= ID_link;
      r_regwrite    <= ID_regwrite;
      r_aluop       <= ID_aluop;
      r_regdst      <= ID_regdst;
      r_sizecontrol <= ID_sizecontrol;
    end
  end

  assign EX_Rs          = r_rs;
  assign EX_Rt          = r_rt_data;
  assign EX_rd          = r_rd;
  assign EX_rt          = r_rt;
  assign EX_funct       = r_funct;
  assign EX_immediate   = r_imm;
  assign EX_memtoreg    = r_memtoreg;
  assign EX_memread     = r_memread;
  assign EX_memwrite    = r_memwrite;
  assign EX_alusource   = r_alusource;
  assign EX_link        = r_link;
  assign EX_regwrite    = r_regwrite;
  assign EX_aluop       = r_aluop;
  assign EX_regdst      = r_regdst;
  assign EX_sizecontrol = r_sizecontrol;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  logic i_clk;
  logic i_rst;
  logic stallID;
`ifdef ID_EX_FLUSH_EN
  logic i_flush;
`endif

  // Field order: Rs, Rt, rd, rt, funct, imm, memtoreg, memread, memwrite,
  // alusource, link, regwrite, aluop, regdst, sizecontrol. Control = [15:0].
  logic [127:0] id_vec;
  logic [127:0] out_vec;

  logic [31:0] ID_Rs, ID_Rt, ID_immediate, EX_Rs, EX_Rt, EX_immediate;
  logic [4:0]  ID_rd, ID_rt, EX_rd, EX_rt, ID_sizecontrol, EX_sizecontrol;
  logic [5:0]  ID_funct, EX_funct;
  logic        ID_memtoreg, ID_memread, ID_memwrite, ID_alusource, ID_link, ID_regwrite;
  logic        EX_memtoreg, EX_memread, EX_memwrite, EX_alusource, EX_link, EX_regwrite;
  logic [2:0]  ID_aluop, EX_aluop;
  logic [1:0]  ID_regdst, EX_regdst;

  assign {ID_Rs, ID_Rt, ID_rd, ID_rt, ID_funct, ID_immediate,
          ID_memtoreg, ID_memread, ID_memwrite, ID_alusource, ID_link, ID_regwrite,
          ID_aluop, ID_regdst, ID_sizecontrol} = id_vec;
  assign out_vec = {EX_Rs, EX_Rt, EX_rd, EX_rt, EX_funct, EX_immediate,
                    EX_memtoreg, EX_memread, EX_memwrite, EX_alusource, EX_link, EX_regwrite,
                    EX_aluop, EX_regdst, EX_sizecontrol};

  id_ex_pipe_reg dut (
    .i_clk(i_clk), .i_rst(i_rst),
`ifdef ID_EX_FLUSH_EN
    .i_flush(i_flush),
`endif
    .stallID(stallID),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_rd(ID_rd), .ID_rt(ID_rt), .ID_funct(ID_funct),
    .ID_immediate(ID_immediate), .ID_memtoreg(ID_memtoreg), .ID_memread(ID_memread),
    .ID_memwrite(ID_memwrite), .ID_alusource(ID_alusource), .ID_link(ID_link),
    .ID_regwrite(ID_regwrite), .ID_aluop(ID_aluop), .ID_regdst(ID_regdst),
    .ID_sizecontrol(ID_sizecontrol),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_rd(EX_rd), .EX_rt(EX_rt), .EX_funct(EX_funct),
    .EX_immediate(EX_immediate), .EX_memtoreg(EX_memtoreg), .EX_memread(EX_memread),
    .EX_memwrite(EX_memwrite), .EX_alusource(EX_alusource), .EX_link(EX_link),
    .EX_regwrite(EX_regwrite), .EX_aluop(EX_aluop), .EX_regdst(EX_regdst),
    .EX_sizecontrol(EX_sizecontrol)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  logic [127:0] sb_q[$];
  logic [127:0] model;   // expected stage contents
  logic [127:0] got;
  logic [127:0] exp_v;

  function automatic logic [127:0] mk(input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [4:0] rd, input logic [4:0] rtt,
                                      input logic [5:0] fn, input logic [31:0] imm,
                                      input logic [5:0] c6, input logic [2:0] op,
                                      input logic [1:0] dst, input logic [4:0] sz);
    return {rs, rt, rd, rtt, fn, imm, c6, op, dst, sz};
  endfunction

  // Advance one edge: update the reference model from the inputs presented,
  // queue the expectation, and sample #1 after the edge.
  task automatic tick();
    logic flush_now;
    flush_now = 1'b0;
`ifdef ID_EX_FLUSH_EN
    flush_now = i_flush;
`endif
    if (!i_rst)         model = '0;
    else if (flush_now) model = {id_vec[127:16], 16'h0};
    else if (!stallID)  model = id_vec;
    sb_q.push_back(model);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    id_vec = mk(32'd8, 32'd0, 5'd0, 5'd0, 6'd0, 32'd15, 6'd0, 3'd4, 2'd0, 5'd0);
    stallID = 1'b0;
    #1;
    i_rst = 1'b0;
    model = '0;
    #1;
    total++;
    if (out_vec !== 128'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", out_vec, 128'h0);
    end
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_load();
    #2;
    i_rst = 1'b1;
    stallID = 1'b0;
    id_vec = mk(32'd8, 32'd9, 5'd2, 5'd3, 6'h6, 32'd15, 6'b111111, 3'd4, 2'd2, 5'd5);
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL load got=%h want=%h", got, exp_v);
    end
    total++;
    if (EX_memwrite !== 1'b1 || EX_sizecontrol !== 5'd5) begin
      bad++;
      $display("FAIL load_fields got=%b/%0d want=1/5", EX_memwrite, EX_sizecontrol);
    end
  endtask

  task automatic test_stall();
    stallID = 1'b1;
    id_vec = mk(32'd9, 32'd8, 5'd3, 5'd2, 6'h5, 32'd8, 6'b001110, 3'd5, 2'd1, 5'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      got = out_vec; exp_v = sb_q.pop_front();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=%h want=%h", i, got, exp_v);
      end
    end
    total++;
    if (EX_Rs !== 32'd8) begin
      bad++;
      $display("FAIL stall_rs got=%0d want=8", EX_Rs);
    end
  endtask

  task automatic test_release();
    stallID = 1'b0;
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL release got=%h want=%h", got, exp_v);
    end
    total++;
    if (EX_Rs !== 32'd9 || EX_immediate !== 32'd8 || EX_aluop !== 3'd5 ||
        EX_regdst !== 2'd1 || EX_sizecontrol !== 5'd4 || EX_regwrite !== 1'b0) begin
      bad++;
      $display("FAIL release_fields got=%0d/%0d/%0d/%0d/%0d/%0d want=9/8/5/1/4/0",
               EX_Rs, EX_immediate, EX_aluop, EX_regdst, EX_sizecontrol, EX_regwrite);
    end
  endtask

  task automatic test_mid_reset();
    id_vec = mk(32'hdeadbeef, 32'h12345678, 5'd31, 5'd17, 6'h2a, 32'hffff_fff0,
                6'b101011, 3'd7, 2'd3, 5'd31);
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL midrst_preload got=%h want=%h", got, exp_v);
    end
    #2;
    i_rst = 1'b0;
    model = '0;
    #1;
    total++;
    if (out_vec !== 128'h0) begin
      bad++;
      $display("FAIL midrst_async got=%h want=%h", out_vec, 128'h0);
    end
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL midrst_held got=%h want=%h", got, exp_v);
    end
    #2;
    i_rst = 1'b1;
    #1;
    total++;
    if (out_vec !== 128'h0) begin
      bad++;
      $display("FAIL midrst_release_no_edge got=%h want=%h", out_vec, 128'h0);
    end
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL midrst_reload got=%h want=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      id_vec = {$urandom, $urandom, $urandom, $urandom};
      stallID = ($urandom_range(0, 3) == 0);
      tick();
      got = out_vec; exp_v = sb_q.pop_front();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL b2b[%0d] stall=%b got=%h want=%h", i, stallID, got, exp_v);
      end
    end
    stallID = 1'b0;
  endtask

`ifdef ID_EX_FLUSH_EN
  task automatic test_flush();
    stallID = 1'b1;
    i_flush = 1'b1;
    id_vec = mk(32'd77, 32'd66, 5'd5, 5'd6, 6'h20, 32'd123, 6'b111111, 3'd7, 2'd3, 5'd31);
    tick();
    got = out_vec; exp_v = sb_q.pop_front();
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL flush got=%h want=%h", got, exp_v);
    end
    total++;
    if (EX_Rs !== 32'd77 || out_vec[15:0] !== 16'h0) begin
      bad++;
      $display("FAIL flush_fields got=%0d/%h want=77/0000", EX_Rs, out_vec[15:0]);
    end
    i_flush = 1'b0;
    stallID = 1'b0;
  endtask
`endif

  initial begin
    i_rst = 1'b1;
    stallID = 1'b0;
`ifdef ID_EX_FLUSH_EN
    i_flush = 1'b0;
`endif
    id_vec = '0;
    model = '0;
    test_reset();
    test_load();
    test_stall();
    test_release();
    test_mid_reset();
    test_back_to_back();
`ifdef ID_EX_FLUSH_EN
    test_flush();
`endif
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
